opb_register_ppc2simulink: RTL and testbench



---
 rtl/opb_slave_pkg.sv | 38 +++
 rtl/opb_register_ppc2simulink_if.sv | 30 +++
 rtl/opb_slave_addr_decode.sv | 21 ++
 rtl/opb_register_ppc2simulink.sv | 97 +++++++++
 tb/tb_opb_register_ppc2simulink.sv | 170 +++++++++++++++++
 5 files changed

// File: rtl/opb_slave_pkg.sv
// Shared definitions for the OPB slave blocks.
// Bus vectors are held MSB-at-[31]: vector bit 31 carries OPB bit 0, and
// byte-enable bit 3 carries OPB_BE[0], which covers the most significant byte.
package opb_slave_pkg;

  localparam int unsigned OpbAw  = 32;
  localparam int unsigned OpbDw  = 32;
  localparam int unsigned OpbBeW = OpbDw / 8;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StAck  = 2'd1,
    StHold = 2'd2
  } opb_state_e;

  // Replace each byte lane of old_w whose enable is set with the lane from new_w.
  function automatic logic [OpbDw-1:0] be_merge(input logic [OpbDw-1:0]  old_w,
                                                input logic [OpbDw-1:0]  new_w,
                                                input logic [OpbBeW-1:0] be);
    logic [OpbDw-1:0] merged;
    merged = old_w;
    for (int i = 0; i < int'(OpbBeW); i++) begin
      if (be[i]) merged[8*i +: 8] = new_w[8*i +: 8];
    end
    return merged;
  endfunction

  // Maps between an OPB-indexed [0:31] view and a [31:0] view, for slaves that
  // keep vectors in OPB bit numbering.
  function automatic logic [OpbDw-1:0] bit_reverse(input logic [OpbDw-1:0] w);
    logic [OpbDw-1:0] r;
    for (int i = 0; i < int'(OpbDw); i++) begin
      r[i] = w[OpbDw-1-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/opb_register_ppc2simulink_if.sv
// OPB slave-side bus bundle.
//   master modport: drives address/data/control, receives slave responses.
//   slave  modport: receives address/data/control, drives Sl_* responses.
// OPB_ABus/OPB_DBus/Sl_DBus: bit 31 = OPB bit 0 (MSB). OPB_BE: bit 3 = OPB_BE[0].
interface opb_register_ppc2simulink_if;
  import opb_slave_pkg::*;

  logic [OpbAw-1:0]  OPB_ABus;
  logic [OpbBeW-1:0] OPB_BE;
  logic [OpbDw-1:0]  OPB_DBus;
  logic              OPB_RNW;
  logic              OPB_select;
  logic              OPB_seqAddr;
  logic [OpbDw-1:0]  Sl_DBus;
  logic              Sl_errAck;
  logic              Sl_retry;
  logic              Sl_toutSup;
  logic              Sl_xferAck;

  modport master (
    output OPB_ABus, OPB_BE, OPB_DBus, OPB_RNW, OPB_select, OPB_seqAddr,
    input  Sl_DBus, Sl_errAck, Sl_retry, Sl_toutSup, Sl_xferAck
  );

  modport slave (
    input  OPB_ABus, OPB_BE, OPB_DBus, OPB_RNW, OPB_select, OPB_seqAddr,
    output Sl_DBus, Sl_errAck, Sl_retry, Sl_toutSup, Sl_xferAck
  );

endinterface

// File: rtl/opb_slave_addr_decode.sv
// Combinational OPB window decode: hit when select is high and the address lies
// in [C_BASEADDR, C_HIGHADDR] inclusive, compared as unsigned values.
//   i_addr   : OPB address
//   i_select : OPB_select
//   o_hit    : address hit qualified by select
module opb_slave_addr_decode #(
  parameter logic [31:0] C_BASEADDR = 32'h0101_3200,
  parameter logic [31:0] C_HIGHADDR = 32'h0101_32FF,
  parameter int unsigned C_AWIDTH   = 32
) (
  input  logic [C_AWIDTH-1:0] i_addr,
  input  logic                i_select,
  output logic                o_hit
);

  localparam logic [C_AWIDTH-1:0] Base = C_BASEADDR[C_AWIDTH-1:0];
  localparam logic [C_AWIDTH-1:0] High = C_HIGHADDR[C_AWIDTH-1:0];

  assign o_hit = i_select && (i_addr >= Base) && (i_addr <= High);

endmodule

// File: rtl/opb_register_ppc2simulink.sv
// OPB slave register written by the PowerPC and presented to fabric user logic.
// Readable over OPB. One transfer per select assertion: IDLE -> ACK -> HOLD.
//   OPB_Clk, OPB_Rst_n : clock, asynchronous active-low reset
//   opb                : OPB slave bundle (address/data/control in, Sl_* out)
//   user_data_out      : register contents ([31] = OPB_DBus bit 0)
//   user_data_valid    : one-cycle pulse in the ack cycle of a write with BE != 0
module opb_register_ppc2simulink
  import opb_slave_pkg::*;
#(
  parameter logic [31:0] C_BASEADDR    = 32'h0101_3200,
  parameter logic [31:0] C_HIGHADDR    = 32'h0101_32FF,
  parameter int unsigned C_OPB_AWIDTH  = 32,
  parameter int unsigned C_OPB_DWIDTH  = 32,
  parameter string       C_FAMILY      = "virtex5",
  parameter logic [31:0] C_RESET_VALUE = 32'h0000_0000
) (
  input  logic                          OPB_Clk,
  input  logic                          OPB_Rst_n,
  opb_register_ppc2simulink_if.slave    opb,
  output logic [31:0]                   user_data_out,
  output logic                          user_data_valid
);

  opb_state_e       r_state, w_state_next;
  logic [OpbDw-1:0] r_data, w_data_next;
  logic [OpbDw-1:0] r_dbus, w_dbus_next;
  logic             r_valid, w_valid_next;
  logic             w_hit;

  // Family and data-width parameters are informational; seqAddr is ignored.
  logic w_unused;
  assign w_unused = ^{opb.OPB_seqAddr, (C_FAMILY == "virtex5"), (C_OPB_DWIDTH == OpbDw)};

  opb_slave_addr_decode #(
    .C_BASEADDR (C_BASEADDR),
    .C_HIGHADDR (C_HIGHADDR),
    .C_AWIDTH   (C_OPB_AWIDTH)
  ) u_decode (
    .i_addr   (opb.OPB_ABus),
    .i_select (opb.OPB_select),
    .o_hit    (w_hit)
  );

  always_comb begin
    w_state_next = r_state;
    w_data_next  = r_data;
    w_dbus_next  = '0;     // read data is only non-zero for the ack cycle
    w_valid_next = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (w_hit) begin
          w_state_next = StAck;
          if (opb.OPB_RNW) begin
            w_dbus_next = r_data;
          end else begin
            w_data_next  = be_merge(r_data, opb.OPB_DBus, opb.OPB_BE);
            w_valid_next = |opb.OPB_BE;
          end
        end
      end
      StAck: begin
        w_state_next = StHold;
      end
      StHold: begin
        // Wait for the master to release select so one assertion gives one ack.
        if (!opb.OPB_select) w_state_next = StIdle;
      end
      default: begin
        w_state_next = StIdle;
      end
    endcase
  end

  always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
    if (!OPB_Rst_n) begin
      r_state <= StIdle;
      r_data  <= C_RESET_VALUE;
      r_dbus  <= '0;
      r_valid <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_data  <= w_data_next;
      r_dbus  <= w_dbus_next;
      r_valid <= w_valid_next;
    end
  end

  assign opb.Sl_DBus    = r_dbus;
  assign opb.Sl_xferAck = (r_state == StAck);
  assign opb.Sl_errAck  = 1'b0;
  assign opb.Sl_retry   = 1'b0;
  assign opb.Sl_toutSup = 1'b0;

  assign user_data_out   = r_data;
  assign user_data_valid = r_valid;

endmodule

// File: tb/tb_opb_register_ppc2simulink.sv
module tb_opb_register_ppc2simulink;

  localparam logic [31:0] ResetVal = 32'hDEAD_BEEF;

  typedef struct {
    int          cyc;
    logic [31:0] dbus;
    logic        valid;
    logic [31:0] ud;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic [31:0] user_data_out;
  logic        user_data_valid;
  int          cyc;
  int          n_tests;
  int          n_fail;
  exp_t        sb[$];

  opb_register_ppc2simulink_if bus ();

  opb_register_ppc2simulink #(
    .C_BASEADDR    (32'h0101_3200),
    .C_HIGHADDR    (32'h0101_32FF),
    .C_OPB_AWIDTH  (32),
    .C_OPB_DWIDTH  (32),
    .C_FAMILY      ("virtex5"),
    .C_RESET_VALUE (ResetVal)
  ) dut (
    .OPB_Clk         (clk),
    .OPB_Rst_n       (rst_n),
    .opb             (bus.slave),
    .user_data_out   (user_data_out),
    .user_data_valid (user_data_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every falling edge, compare against the scoreboard head on an ack,
  // otherwise require idle outputs.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (bus.Sl_xferAck === 1'b1) begin
        if (sb.size() == 0) begin
          chk("unexpected_ack", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          chk("ack_cycle", cyc, e.cyc);
          chk("ack_dbus", bus.Sl_DBus, e.dbus);
          chk("ack_valid", {31'd0, user_data_valid}, {31'd0, e.valid});
          chk("ack_user_data", user_data_out, e.ud);
        end
      end else begin
        chk("idle_ack", {31'd0, bus.Sl_xferAck}, 32'd0);
        chk("idle_dbus", bus.Sl_DBus, 32'd0);
        chk("idle_valid", {31'd0, user_data_valid}, 32'd0);
      end
      chk("tied_zero", {29'd0, bus.Sl_errAck, bus.Sl_retry, bus.Sl_toutSup}, 32'd0);
    end
  end

  task automatic bus_idle();
    bus.OPB_select  = 1'b0;
    bus.OPB_ABus    = '0;
    bus.OPB_DBus    = '0;
    bus.OPB_BE      = '0;
    bus.OPB_RNW     = 1'b0;
    bus.OPB_seqAddr = 1'b0;
  endtask

  // One transfer with select held for 'hold' rising edges, then two idle edges.
  task automatic xfer(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] be,
                      input logic rnw, input int hold, input logic hit,
                      input logic [31:0] e_dbus, input logic e_valid, input logic [31:0] e_ud);
    exp_t e;
    @(posedge clk);
    #1;
    bus.OPB_ABus   = addr;
    bus.OPB_DBus   = data;
    bus.OPB_BE     = be;
    bus.OPB_RNW    = rnw;
    bus.OPB_select = 1'b1;
    if (hit) begin
      e.cyc = cyc + 1;
      e.dbus = e_dbus;
      e.valid = e_valid;
      e.ud = e_ud;
      sb.push_back(e);
    end
    repeat (hold) @(posedge clk);
    #1;
    bus_idle();
    repeat (2) @(posedge clk);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_n   = 1'b0;
    bus_idle();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_user_data", user_data_out, ResetVal);
    chk("rst_ack", {31'd0, bus.Sl_xferAck}, 32'd0);
    chk("rst_dbus", bus.Sl_DBus, 32'd0);
    chk("rst_valid", {31'd0, user_data_valid}, 32'd0);
    rst_n = 1'b1;

    // Full write, byte-lane write, empty-BE write, read-back.
    xfer(32'h0101_3200, 32'h1234_5678, 4'b1111, 1'b0, 1, 1'b1, 32'h0, 1'b1, 32'h1234_5678);
    xfer(32'h0101_3200, 32'hAABB_CCDD, 4'b0100, 1'b0, 1, 1'b1, 32'h0, 1'b1, 32'h12BB_5678);
    xfer(32'h0101_3200, 32'hFFFF_FFFF, 4'b0000, 1'b0, 1, 1'b1, 32'h0, 1'b0, 32'h12BB_5678);
    xfer(32'h0101_32FC, 32'h0,         4'b1111, 1'b1, 1, 1'b1, 32'h12BB_5678, 1'b0,
         32'h12BB_5678);

    // Just outside the window on both sides: no ack, no change.
    xfer(32'h0101_3300, 32'h0, 4'b1111, 1'b0, 5, 1'b0, 32'h0, 1'b0, 32'h0);
    xfer(32'h0101_31FF, 32'h0, 4'b1111, 1'b0, 3, 1'b0, 32'h0, 1'b0, 32'h0);
    @(negedge clk);
    chk("out_of_range_unchanged", user_data_out, 32'h12BB_5678);

    // Top of window, select held 4 edges: exactly one ack (extras are caught).
    xfer(32'h0101_32FF, 32'h0000_00EE, 4'b0001, 1'b0, 4, 1'b1, 32'h0, 1'b1, 32'h12BB_56EE);
    // Two back-to-back reads.
    xfer(32'h0101_3240, 32'h0, 4'b1111, 1'b1, 1, 1'b1, 32'h12BB_56EE, 1'b0, 32'h12BB_56EE);
    xfer(32'h0101_3244, 32'h0, 4'b0000, 1'b1, 1, 1'b1, 32'h12BB_56EE, 1'b0, 32'h12BB_56EE);

    // Reset lands on the IDLE->ACK edge: no ack, register back to reset value.
    @(posedge clk);
    #1;
    bus.OPB_ABus   = 32'h0101_3200;
    bus.OPB_DBus   = 32'h5555_5555;
    bus.OPB_BE     = 4'b1111;
    bus.OPB_RNW    = 1'b0;
    bus.OPB_select = 1'b1;
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    bus_idle();
    @(negedge clk);
    chk("mid_rst_user_data", user_data_out, ResetVal);
    rst_n = 1'b1;
    xfer(32'h0101_3200, 32'h0000_0001, 4'b1111, 1'b0, 1, 1'b1, 32'h0, 1'b1, 32'h0000_0001);

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("scoreboard_drained", sb.size(), 32'd0);
    chk("final_user_data", user_data_out, 32'h0000_0001);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
